flash_arbiter: RTL and testbench
================================

# flash_arbiter

Two-port arbiter and sequencer in front of the flash driver. It shares the single flash driver between a read-only CPU fetch/load port (port 0) and a programmer port (port 1) that can issue read, word-program and block-erase. It grants requests round-robin and drives the driver's level/pulse enables. It tracks the driver's `busy` handshake to completion, returns read data and acknowledges each requester with a one-cycle pulse. A watchdog reports an error if the driver never accepts a command.

## Interface
Parameters:
- `TIMEOUT_CYC`, 16: cycles allowed in WAIT_BUSY before the command is aborted with an error.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `m0_req`  in  1  port 0 read request; held until `m0_ack`.
- `m0_addr`  in  22  port 0 halfword address; stable while `m0_req`=1.
- `m0_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`  out  16  read data; valid with `m0_ack`, held until the next port-0 ack.
- `m1_req`  in  1  port 1 request; held until `m1_ack`.
- `m1_op`  in  2  0=read, 1=write, 2=erase, 3=illegal.
- `m1_addr`  in  22  port 1 halfword address.
- `m1_wdata`  in  16  program data.
- `m1_ack`  out  1  one-cycle completion pulse.
- `m1_rdata`  out  16  read data; valid with `m1_ack`.
- `m1_err`  out  1  valid with `m1_ack`: 1 = timeout or illegal op.
- `drv_addr`  out  22  address to driver.
- `drv_wdata`  out  16  data to driver.
- `drv_rdata`  in  16  driver read data.
- `drv_read`  out  1  level; held for the whole read.
- `drv_write`  out  1  one-cycle pulse.
- `drv_erase`  out  1  one-cycle pulse.
- `drv_busy`  in  1  driver busy; rises one cycle after it accepts a command.
- `owner`  out  2  bit i = port i currently granted; 0 when idle.

## Operation
- States: SYNC, IDLE, WAIT_BUSY, WAIT_DONE, RELEASE.
- Reset values:
  - State goes to SYNC.
  - All `drv_*` enables are 0; `drv_addr`/`drv_wdata` are 0.
  - Both acks are 0; `m1_err` is 0.
  - `m0_rdata`/`m1_rdata` are 0; `owner` is 0.
  - `last_grant` is 1.
- SYNC: leave for IDLE once `drv_busy`=0 has been sampled on 2 consecutive cycles. This covers a reset that lands while the driver is mid-program or mid-erase.
- IDLE, grant selection:
  - If only one `req` is high, that port wins.
  - If both are high, the port ≠ `last_grant` wins.
  - The winner's address/data are registered onto `drv_addr`/`drv_wdata`; `owner` and `last_grant` are set.
  - The matching enable is set and the state goes to WAIT_BUSY with the counter cleared.
  - `m1_op`=3 asserts no enable; the state goes straight to RELEASE with `m1_ack`=1 and `m1_err`=1.
- WAIT_BUSY:
  - `drv_write`/`drv_erase` are cleared; they are high for exactly one cycle.
  - `drv_read` stays high.
  - If `drv_busy`=1, go to WAIT_DONE.
  - Else if counter = TIMEOUT_CYC−1: clear all enables, go to RELEASE and ack with error. Port 0 gets `m0_rdata`=16'hFFFF; port 1 gets `m1_err`=1.
  - Otherwise increment the counter.
- WAIT_DONE:
  - On `drv_busy`=0, a read latches `drv_rdata` into the owner's rdata and clears `drv_read`.
  - Then assert the owner's ack (err=0) and go to RELEASE.
- RELEASE:
  - Clear ack, `m1_err` and `owner`; go to IDLE.
  - The single cycle gives the driver time to return to its idle state after `drv_read` falls.
- Requester rule: `req` must be low in the cycle after ack. A `req` still high in IDLE is treated as a new request.

## Timing
- Ack is a registered single-cycle pulse, visible during the RELEASE cycle.
- Write/erase: `drv_*` pulse at IDLE+1. Ack comes 1 cycle after the first `drv_busy`=0 sample following busy-high.
- Read: `drv_read` is high from IDLE+1 until the cycle after busy falls. Rdata is captured on that same edge and ack coincides with rdata valid.
- Minimum turnaround between grants is 1 IDLE cycle after RELEASE. Two back-to-back requesters alternate.
- The counter is 8 bits wide; the minimum TIMEOUT_CYC is 2.

## Structure
- Shared package `flash_arb_pkg`: op codes (OP_READ, OP_WRITE, OP_ERASE), state encodings, default TIMEOUT_CYC.
- One sub-module: `flash_rr_pick`, a combinational 2-way round-robin chooser taking `req[1:0]` and `last_grant` and producing a one-hot grant.
- Everything else lives in `flash_arbiter`.

## Test plan
- Port 0 read of addr 22'h000010 with the driver model returning 16'hBEEF → `drv_read` high until busy falls; one `m0_ack` pulse; `m0_rdata`=16'hBEEF; `owner` is 2'b01 during the transfer.
- Port 1 write (op=1, addr 22'h000400, data 16'h1234) → `drv_write` high exactly 1 cycle; `drv_wdata`=16'h1234; `m1_ack` with `m1_err`=0 after busy falls.
- Both ports request continuously from reset → grants alternate 0,1,0,1; each ack arrives before the next grant.
- Driver model never raises busy, TIMEOUT_CYC=16 → enable dropped after 16 cycles; `m1_ack`=1 with `m1_err`=1 (or `m0_rdata`=16'hFFFF for port 0).
- `m1_op`=3 → no `drv_*` activity; `m1_ack` and `m1_err` both pulse 1 cycle after the grant.
- `rst`=0 asserted during an erase while `drv_busy`=1 → outputs at reset values; no grant until busy has been low for 2 cycles; then a pending port-0 read completes normally.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// flash_arb_pkg: op codes, FSM states and defaults shared by the flash arbiter slice.
package flash_arb_pkg;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_ERASE = 2'd2, OP_ILL = 2'd3} op_t;
  typedef enum logic [2:0] {SYNC, IDLE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;
endpackage

// File: rtl/flash_rr_pick.sv
// flash_rr_pick: two-way round-robin chooser producing a one-hot grant.
module flash_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = &req ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one flash driver between a CPU read port and a programmer port.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [21:0] m0_addr,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic [1:0]  m1_op,
  input  logic [21:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        m1_err,
  output logic [21:0] drv_addr,
  output logic [15:0] drv_wdata,
  input  logic [15:0] drv_rdata,
  output logic        drv_read,
  output logic        drv_write,
  output logic        drv_erase,
  input  logic        drv_busy,
  output logic [1:0]  owner
);
  state_t     state;
  logic [7:0] cnt;
  logic       sync_seen;
  logic       last_grant;
  logic [1:0] grant;
  flash_rr_pick u_pick (.req({m1_req, m0_req}), .last_grant(last_grant), .grant(grant));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SYNC;
      cnt        <= '0;
      sync_seen  <= 1'b0;
      last_grant <= 1'b1;
      owner      <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      drv_addr   <= '0;
      drv_wdata  <= '0;
      drv_read   <= 1'b0;
      drv_write  <= 1'b0;
      drv_erase  <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          // the driver may still be finishing a command issued before reset
          sync_seen <= !drv_busy;
          if (!drv_busy && sync_seen) state <= IDLE;
        end
        IDLE: if (|grant) begin
          owner      <= grant;
          last_grant <= grant[1];
          drv_addr   <= grant[1] ? m1_addr : m0_addr;
          drv_wdata  <= grant[1] ? m1_wdata : '0;
          cnt        <= '0;
          if (grant[1] && m1_op == OP_ILL) begin
            m1_ack <= 1'b1;
            m1_err <= 1'b1;
            state  <= RELEASE;
          end else begin
            drv_read  <= grant[0] || m1_op == OP_READ;
            drv_write <= grant[1] && m1_op == OP_WRITE;
            drv_erase <= grant[1] && m1_op == OP_ERASE;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          drv_write <= 1'b0;
          drv_erase <= 1'b0;
          if (drv_busy) state <= WAIT_DONE;
          else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
            drv_read <= 1'b0;
            m0_ack   <= owner[0];
            m1_ack   <= owner[1];
            m1_err   <= owner[1];
            if (owner[0]) m0_rdata <= 16'hFFFF;
            state <= RELEASE;
          end else cnt <= cnt + 8'd1;
        end
        WAIT_DONE: if (!drv_busy) begin
          if (drv_read && owner[0]) m0_rdata <= drv_rdata;
          if (drv_read && owner[1]) m1_rdata <= drv_rdata;
          drv_read <= 1'b0;
          m0_ack   <= owner[0];
          m1_ack   <= owner[1];
          state    <= RELEASE;
        end
        RELEASE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
          owner  <= '0;
          state  <= IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: randomized and directed checks of flash_arbiter against a transaction-timeline model.
module tb_flash_arbiter;
  localparam int TO  = 16;
  localparam int BIG = 1 << 30;
  typedef struct {logic [1:0] op; logic [21:0] addr; logic [15:0] wdata;} txn_t;
  logic clk = 1'b0, rst = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0, m0_ack, m1_ack, m1_err;
  logic [21:0] m0_addr = '0, m1_addr = '0, drv_addr;
  logic [15:0] m1_wdata = '0, m0_rdata, m1_rdata, drv_wdata, drv_rdata = '0;
  logic [1:0] m1_op = '0, owner;
  logic drv_read, drv_write, drv_erase, drv_busy = 1'b0;
  flash_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata),
    .drv_read(drv_read), .drv_write(drv_write), .drv_erase(drv_erase),
    .drv_busy(drv_busy), .owner(owner)
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  txn_t q0[$], q1[$];
  int grants[$];
  logic rst_cmd = 1'b0;
  // model state
  bit in_txn = 0, rose = 0, ready = 0, prev_rst = 0, pend_grant = 0, last = 1;
  int run = 0, g_cyc = 0, ack_cyc = 0, t_port = 0;
  logic [1:0] t_op = '0, pend_win = '0;
  logic [21:0] t_addr = '0;
  logic [15:0] t_wdata = '0, exp_rd0 = '0, exp_rd1 = '0;
  // driver model and configuration
  bit d_act = 0, prev_en = 0, cfg_rand = 0, cfg_dead = 0;
  int d_start = 0, d_stop = 0, cfg_d = 0, cfg_l = 1, gap0 = 0, gap1 = 0;
  // literal pins
  int rd_cnt, wr_cnt, er_cnt, own01, m0ack_cnt, m1ack_cnt, err_cnt;
  logic [15:0] wd_seen;

  function automatic logic [15:0] data_of(logic [21:0] a);
    return a == 22'h10 ? 16'hBEEF : a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr();
    rd_cnt = 0; wr_cnt = 0; er_cnt = 0; own01 = 0; m0ack_cnt = 0; m1ack_cnt = 0; err_cnt = 0;
    wd_seen = '0;
    grants.delete();
  endtask

  task automatic step();
    logic [1:0] req, win;
    bit was, ack_exp, en, nb, nr0, nr1, ign;
    logic [15:0] nrd;
    int dd, ll;
    was = 0;
    nrd = drv_rdata;
    @(negedge clk);
    cyc++;
    req = {m1_req, m0_req};
    rd_cnt += int'(drv_read); wr_cnt += int'(drv_write); er_cnt += int'(drv_erase);
    own01 += int'(owner == 2'b01); m0ack_cnt += int'(m0_ack); m1ack_cnt += int'(m1_ack);
    err_cnt += int'(m1_err);
    if (drv_write) wd_seen = drv_wdata;
    if (!prev_rst) begin
      chk("rst_outs", {m0_rdata, m1_rdata, drv_wdata, owner, m0_ack, m1_ack, m1_err,
                       drv_read, drv_write, drv_erase}, 64'd0);
      chk("rst_addr", drv_addr, 64'd0);
    end else begin
      if (pend_grant) begin
        chk("grant", owner, pend_win);
        in_txn = 1; rose = 0; g_cyc = cyc;
        t_port = int'(pend_win[1]);
        t_op = pend_win[1] ? m1_op : 2'd0;
        t_addr = pend_win[1] ? m1_addr : m0_addr;
        t_wdata = m1_wdata;
        ack_cyc = (t_op == 2'd3) ? cyc : cyc + TO;
        chk("drv_addr", drv_addr, t_addr);
        if (t_port == 1) chk("drv_wdata", drv_wdata, t_wdata);
        grants.push_back(t_port);
      end
      if (in_txn && drv_busy) begin rose = 1; ack_cyc = BIG; end
      if (in_txn && rose && !drv_busy && ack_cyc == BIG) ack_cyc = cyc + 1;
      if (in_txn) begin
        was = 1;
        ack_exp = (cyc == ack_cyc);
        chk("owner", owner, t_port == 1 ? 2'b10 : 2'b01);
        chk("m0_ack", m0_ack, ack_exp && t_port == 0);
        chk("m1_ack", m1_ack, ack_exp && t_port == 1);
        chk("m1_err", m1_err, ack_exp && t_port == 1 && (t_op == 2'd3 || !rose));
        chk("drv_read", drv_read, t_op == 2'd0 && cyc < ack_cyc);
        chk("drv_write", drv_write, t_op == 2'd1 && cyc == g_cyc);
        chk("drv_erase", drv_erase, t_op == 2'd2 && cyc == g_cyc);
        if (ack_exp) begin
          if (t_port == 0) exp_rd0 = rose ? data_of(t_addr) : 16'hFFFF;
          else if (t_op == 2'd0 && rose) exp_rd1 = data_of(t_addr);
          in_txn = 0;
        end
      end else
        chk("idle_outs", {owner, m0_ack, m1_ack, m1_err, drv_read, drv_write, drv_erase}, 64'd0);
      chk("m0_rdata", m0_rdata, exp_rd0);
      chk("m1_rdata", m1_rdata, exp_rd1);
    end
    // grant prediction for the next cycle
    win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
    pend_grant = rst && ready && !was && req != 2'b00;
    pend_win = win;
    if (pend_grant) last = win[1];
    if (!rst) begin
      in_txn = 0; ready = 0; run = 0; last = 1; exp_rd0 = '0; exp_rd1 = '0; pend_grant = 0;
    end else if (!ready) begin
      run = drv_busy ? 0 : run + 1;
      ready = run >= 2;
    end
    prev_rst = rst;
    // driver: accepts on a rising enable, busy one cycle after acceptance plus any delay
    en = drv_read | drv_write | drv_erase;
    dd = cfg_rand ? int'($urandom_range(0, 3)) : cfg_d;
    ll = cfg_rand ? int'($urandom_range(1, 6)) : cfg_l;
    ign = cfg_dead || (cfg_rand && $urandom_range(0, 9) == 0);
    if (!d_act && !ign && en && !prev_en) begin
      d_act = 1; d_start = cyc + 1 + dd; d_stop = d_start + ll; nrd = data_of(drv_addr);
    end
    nb = d_act && cyc + 1 >= d_start && cyc + 1 < d_stop;
    if (d_act && cyc + 1 >= d_stop) d_act = 0;
    prev_en = en;
    // requesters
    if (m0_ack) begin void'(q0.pop_front()); gap0 = cfg_rand ? int'($urandom_range(0, 3)) : 0; nr0 = 0; end
    else if (q0.size() == 0) nr0 = 0;
    else if (!m0_req && gap0 > 0) begin gap0--; nr0 = 0; end
    else nr0 = 1;
    if (m1_ack) begin void'(q1.pop_front()); gap1 = cfg_rand ? int'($urandom_range(0, 3)) : 0; nr1 = 0; end
    else if (q1.size() == 0) nr1 = 0;
    else if (!m1_req && gap1 > 0) begin gap1--; nr1 = 0; end
    else nr1 = 1;
    @(posedge clk);
    #1;
    rst = rst_cmd;
    drv_busy = nb;
    drv_rdata = nrd;
    m0_req = nr0;
    if (nr0) m0_addr = q0[0].addr;
    m1_req = nr1;
    if (nr1) begin m1_op = q1[0].op; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; end
  endtask

  task automatic run_all();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in_txn || m0_req || m1_req) && k < 3000) begin
      step();
      k++;
    end
    if (k >= 3000) begin
      total++; bad++;
      $display("FAIL drain_bound cyc=%0d got=stuck want=idle", cyc);
    end
    repeat (3) step();
  endtask

  initial begin
    int k;
    txn_t t;
    clr();
    repeat (3) step();
    rst_cmd = 1'b1;
    repeat (4) step();
    // port 0 read
    clr(); cfg_d = 0; cfg_l = 3;
    q0.push_back('{2'd0, 22'h000010, 16'h0});
    run_all();
    chk("t1_rd_cycles", rd_cnt, 5);
    chk("t1_owner_cycles", own01, 6);
    chk("t1_acks", m0ack_cnt, 1);
    chk("t1_rdata", m0_rdata, 16'hBEEF);
    // port 1 write
    clr(); cfg_l = 2;
    q1.push_back('{2'd1, 22'h000400, 16'h1234});
    run_all();
    chk("t2_wr_cycles", wr_cnt, 1);
    chk("t2_wdata", wd_seen, 16'h1234);
    chk("t2_acks", m1ack_cnt, 1);
    chk("t2_err", err_cnt, 0);
    // both ports back to back
    clr(); cfg_l = 2;
    q0.push_back('{2'd0, 22'h000100, 16'h0}); q0.push_back('{2'd0, 22'h000101, 16'h0});
    q1.push_back('{2'd0, 22'h000200, 16'h0}); q1.push_back('{2'd0, 22'h000201, 16'h0});
    run_all();
    chk("t3_ngrants", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("t3_g0", grants[0], 0); chk("t3_g1", grants[1], 1);
      chk("t3_g2", grants[2], 0); chk("t3_g3", grants[3], 1);
    end
    // dead driver
    clr(); cfg_dead = 1;
    q0.push_back('{2'd0, 22'h000033, 16'h0});
    run_all();
    chk("t4_rd_cycles", rd_cnt, 16);
    chk("t4_rdata", m0_rdata, 16'hFFFF);
    clr();
    q1.push_back('{2'd1, 22'h000044, 16'h5555});
    run_all();
    chk("t4_wr_cycles", wr_cnt, 1);
    chk("t4_err", err_cnt, 1);
    cfg_dead = 0;
    // illegal op
    clr();
    q1.push_back('{2'd3, 22'h000055, 16'h0});
    run_all();
    chk("t5_enables", rd_cnt + wr_cnt + er_cnt, 0);
    chk("t5_err", err_cnt, 1);
    chk("t5_acks", m1ack_cnt, 1);
    // reset during erase
    clr(); cfg_d = 0; cfg_l = 12;
    q1.push_back('{2'd2, 22'h003000, 16'h0});
    k = 0;
    while (!drv_busy && k < 40) begin step(); k++; end
    chk("t6_busy_seen", drv_busy, 1'b1);
    q0.push_back('{2'd0, 22'h000020, 16'h0});
    repeat (2) step();
    rst_cmd = 1'b0;
    q1.delete();
    repeat (2) step();
    rst_cmd = 1'b1;
    clr(); cfg_l = 3;
    run_all();
    chk("t6_acks", m0ack_cnt, 1);
    chk("t6_rdata", m0_rdata, 16'h5A7A);
    chk("t6_erase", er_cnt, 0);
    // randomized traffic
    cfg_rand = 1;
    for (int i = 0; i < 60; i++) begin
      t.addr = 22'($urandom);
      t.wdata = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin t.op = 2'd0; q0.push_back(t); end
      else begin t.op = 2'($urandom_range(0, 3)); q1.push_back(t); end
    end
    run_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
